// File: rtl/ub_host_bridge.sv
// ---------------------------------------------------------------------------
// ub_host_bridge
//
// Host-side bridge onto the master port of the unified buffer. Accepts one
// row read/write command per cycle, issues it on registered master_* outputs,
// tracks reads through the buffer's 3-cycle read pipeline and returns read
// rows in issue order through a small response FIFO. Read admission is
// credit-based, so a response always has a FIFO slot when it arrives.
//
// Optional feature: define UB_BRIDGE_ADDR_CHK_EN to reject rows at or above
// TILE_WIDTH (flagged on cmd_err, reads answered with an all-zero row).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   buf_enable          shared enable of the unified buffer pipeline
//   cmd_*               command channel (valid/ready, write, addr, byte_en, wdata)
//   rsp_*               read-response channel (valid/ready, rdata)
//   master_*            unified buffer master port
//   cmd_err             sticky address error flag
// ---------------------------------------------------------------------------
module ub_host_bridge #(
    parameter int unsigned MATRIX_WIDTH = 14,
    parameter int unsigned TILE_WIDTH   = 4096,
    parameter int unsigned RSP_DEPTH    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 buf_enable,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic                                 cmd_write,
    input  logic [$clog2(TILE_WIDTH):0]          cmd_addr,
    input  logic [MATRIX_WIDTH-1:0]              cmd_byte_en,
    input  logic [MATRIX_WIDTH-1:0][7:0]         cmd_wdata,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [MATRIX_WIDTH-1:0][7:0]         rsp_rdata,
    output logic [$clog2(TILE_WIDTH):0]          master_addr,
    output logic                                 master_en,
    output logic [MATRIX_WIDTH-1:0]              master_write_en,
    output logic [MATRIX_WIDTH-1:0][7:0]         master_write_port,
    input  logic [MATRIX_WIDTH-1:0][7:0]         master_read_port,
    output logic                                 cmd_err
);

    // Address carries one bit beyond the row range so out-of-range rows are
    // representable and can be detected.
    localparam int unsigned ADDR_W = $clog2(TILE_WIDTH) + 1;
    localparam int unsigned PTR_W  = $clog2(RSP_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned SUM_W  = CNT_W + 1;

    typedef logic [MATRIX_WIDTH-1:0][7:0] row_t;

    // Issue registers
    logic                    master_en_q,         master_en_d;
    logic [MATRIX_WIDTH-1:0] master_write_en_q,   master_write_en_d;
    logic [ADDR_W-1:0]       master_addr_q,       master_addr_d;
    row_t                    master_write_port_q, master_write_port_d;

    // Read tracker: rd_issue_q marks a read in its issue cycle, stage_q follows
    // the buffer's read pipeline. zero flags mark reads answered with zeros.
    logic                    rd_issue_q, rd_issue_d;
    logic                    rd_zero_q,  rd_zero_d;
    logic [2:0]              stage_q,    stage_d;
    logic [2:0]              zero_q,     zero_d;

    // Response FIFO
    row_t                    fifo_q [RSP_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q,  count_d;

    // Held low through reset and its following cycle so cmd_ready stays 0
    // while rst is asserted without depending on rst combinationally.
    logic                    rdy_en_q;
    logic                    cmd_err_q, cmd_err_d;

    logic                    accept;
    logic                    addr_bad;
    logic                    push;
    logic                    pop;
    logic                    credit_ok;
    logic [SUM_W-1:0]        in_use;

`ifdef UB_BRIDGE_ADDR_CHK_EN
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(TILE_WIDTH);
    assign addr_bad = (cmd_addr >= ADDR_LIMIT);
    assign cmd_err  = cmd_err_q;
`else
    assign addr_bad = 1'b0;
    assign cmd_err  = 1'b0;
`endif

    // Everything that will eventually need a FIFO slot: reads being issued,
    // reads in the buffer pipeline and rows already queued.
    assign in_use = SUM_W'(rd_issue_q) + SUM_W'(stage_q[0]) + SUM_W'(stage_q[1])
                  + SUM_W'(stage_q[2]) + SUM_W'(count_q);
    assign credit_ok = (in_use < SUM_W'(RSP_DEPTH));

    assign cmd_ready = rdy_en_q && buf_enable && (cmd_write || credit_ok);
    assign accept    = cmd_valid && cmd_ready;

    assign rsp_valid = (count_q != '0);
    assign rsp_rdata = rsp_valid ? fifo_q[rd_ptr_q] : '0;
    assign pop       = rsp_valid && rsp_ready;
    assign push      = stage_q[2] && buf_enable;

    assign master_en         = master_en_q;
    assign master_write_en   = master_write_en_q;
    assign master_addr       = master_addr_q;
    assign master_write_port = master_write_port_q;

    always_comb begin
        master_en_d         = master_en_q;
        master_write_en_d   = master_write_en_q;
        master_addr_d       = master_addr_q;
        master_write_port_d = master_write_port_q;
        rd_issue_d          = rd_issue_q;
        rd_zero_d           = rd_zero_q;
        stage_d             = stage_q;
        zero_d              = zero_q;
        cmd_err_d           = cmd_err_q | (accept && addr_bad);

        // Issue and tracking freeze with the buffer pipeline; accept already
        // implies buf_enable.
        if (buf_enable) begin
            master_en_d       = accept && !addr_bad;
            master_write_en_d = (accept && cmd_write && !addr_bad) ? cmd_byte_en : '0;
            if (accept && !addr_bad) begin
                master_addr_d = cmd_addr;
            end
            if (accept && cmd_write && !addr_bad) begin
                master_write_port_d = cmd_wdata;
            end
            rd_issue_d = accept && !cmd_write;
            rd_zero_d  = accept && !cmd_write && addr_bad;
            stage_d    = {stage_q[1:0], rd_issue_q};
            zero_d     = {zero_q[1:0], rd_zero_q};
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            master_en_q         <= 1'b0;
            master_write_en_q   <= '0;
            master_addr_q       <= '0;
            master_write_port_q <= '0;
            rd_issue_q          <= 1'b0;
            rd_zero_q           <= 1'b0;
            stage_q             <= '0;
            zero_q              <= '0;
            wr_ptr_q            <= '0;
            rd_ptr_q            <= '0;
            count_q             <= '0;
            rdy_en_q            <= 1'b0;
            cmd_err_q           <= 1'b0;
        end else begin
            master_en_q         <= master_en_d;
            master_write_en_q   <= master_write_en_d;
            master_addr_q       <= master_addr_d;
            master_write_port_q <= master_write_port_d;
            rd_issue_q          <= rd_issue_d;
            rd_zero_q           <= rd_zero_d;
            stage_q             <= stage_d;
            zero_q              <= zero_d;
            wr_ptr_q            <= wr_ptr_d;
            rd_ptr_q            <= rd_ptr_d;
            count_q             <= count_d;
            rdy_en_q            <= 1'b1;
            cmd_err_q           <= cmd_err_d;
        end
    end

    // Storage needs no reset: rsp_rdata is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_q[wr_ptr_q] <= zero_q[2] ? '0 : master_read_port;
        end
    end

endmodule

// File: tb/tb_ub_host_bridge.sv
module tb_ub_host_bridge;

    localparam int unsigned MW = 14;
    localparam int unsigned TW = 4096;
    localparam int unsigned AW = 13;

    typedef logic [MW-1:0][7:0] row_t;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [MW-1:0] be;
        row_t          d;
        row_t          exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          buf_enable = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [MW-1:0] cmd_byte_en = '0;
    row_t          cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    row_t          rsp_rdata;
    logic [AW-1:0] master_addr;
    logic          master_en;
    logic [MW-1:0] master_write_en;
    row_t          master_write_port;
    row_t          master_read_port;
    logic          cmd_err;

    int errors = 0;
    int checks = 0;
    row_t expq[$];
    vec_t vt[11];

    ub_host_bridge #(
        .MATRIX_WIDTH(MW),
        .TILE_WIDTH(TW),
        .RSP_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .buf_enable(buf_enable),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_byte_en(cmd_byte_en),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .master_addr(master_addr),
        .master_en(master_en),
        .master_write_en(master_write_en),
        .master_write_port(master_write_port),
        .master_read_port(master_read_port),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // Unified buffer model: byte-masked writes, 3-stage read pipeline frozen
    // by buf_enable, rows 0..4 preloaded with 0xC0+row, everything else zero.
    row_t mem [TW];
    row_t pipe0, pipe1, pipe2;
    row_t nrow;
    assign master_read_port = pipe2;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TW; i++) begin
                mem[i] <= (i < 5) ? {MW{8'(8'hC0 + i)}} : '0;
            end
            pipe0 <= '0;
            pipe1 <= '0;
            pipe2 <= '0;
        end else if (buf_enable) begin
            pipe1 <= pipe0;
            pipe2 <= pipe1;
            if (master_en) begin
                nrow  = mem[master_addr[AW-2:0]];
                pipe0 <= nrow;
                for (int i = 0; i < MW; i++) begin
                    if (master_write_en[i]) nrow[i] = master_write_port[i];
                end
                mem[master_addr[AW-2:0]] <= nrow;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response scoreboard: every pop must match the oldest expected row.
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst && rsp_valid && rsp_ready) begin
            if (expq.size() == 0) chk("spurious_rsp", {127'b0, rsp_valid}, 128'd0);
            else chk("rsp_data", rsp_rdata, expq.pop_front());
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // Called at a negedge; returns at the negedge of the issue cycle.
    task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [MW-1:0] be,
                          input row_t d, input row_t exp_rd);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_byte_en = be; cmd_wdata = d;
        #1;
        while (!cmd_ready && n < 40) begin
            @(negedge clk); #1; n++;
        end
        chk("cmd_ready", {127'b0, cmd_ready}, 128'd1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (!w) expq.push_back(exp_rd);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("issue_en", {127'b0, master_en}, 128'd1);
        chk("issue_addr", master_addr, a);
        chk("issue_wen", master_write_en, w ? be : '0);
        if (w) chk("issue_wdata", master_write_port, d);
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 60) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        chk("drain", expq.size(), 0);
    endtask

    initial begin
        int cyc;
        row_t r18;
        r18 = 112'h0E0D0C0B0A090807060504030201;
        vt[0]  = '{1'b1, 13'd5,    14'h3FFF, r18,            '0};
        vt[1]  = '{1'b0, 13'd5,    14'h0000, '0,             r18};
        vt[2]  = '{1'b1, 13'd7,    14'h0001, {MW{8'hAA}},    '0};
        vt[3]  = '{1'b0, 13'd7,    14'h0000, '0,             112'hAA};
        vt[4]  = '{1'b1, 13'd10,   14'h3000, {MW{8'h55}},    '0};
        vt[5]  = '{1'b0, 13'd10,   14'h0000, '0,             112'h5555_0000_0000_0000_0000_0000_0000};
        vt[6]  = '{1'b1, 13'd4095, 14'h3FFF, {MW{8'hFF}},    '0};
        vt[7]  = '{1'b0, 13'd4095, 14'h0000, '0,             {MW{8'hFF}}};
        vt[8]  = '{1'b0, 13'd5,    14'h3FFF, '0,             r18};
        vt[9]  = '{1'b1, 13'd5,    14'h2001, {MW{8'h3C}},    '0};
        vt[10] = '{1'b0, 13'd5,    14'h0000, '0,             112'h3C0D0C0B0A09080706050403023C};

        // Reset state (cmd_write=1 so cmd_ready can only be low because of reset)
        rst = 1'b1; buf_enable = 1'b1; cmd_write = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_master_en", {127'b0, master_en}, 128'd0);
        chk("rst_master_wen", master_write_en, 128'd0);
        chk("rst_master_addr", master_addr, 128'd0);
        chk("rst_master_wport", master_write_port, 128'd0);
        chk("rst_rsp_valid", {127'b0, rsp_valid}, 128'd0);
        chk("rst_rsp_rdata", rsp_rdata, 128'd0);
        chk("rst_cmd_err", {127'b0, cmd_err}, 128'd0);
        chk("rst_cmd_ready", {127'b0, cmd_ready}, 128'd0);
        rst = 1'b0; rsp_ready = 1'b1; cmd_write = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Table of directed writes/reads
        for (int i = 0; i < 11; i++) begin
            do_cmd(vt[i].w, vt[i].a, vt[i].be, vt[i].d, vt[i].exp);
        end
        drain();
        chk("no_err_default", {127'b0, cmd_err}, 128'd0);

        // Read latency: rsp_valid five cycles after acceptance
        do_cmd(1'b0, 13'd5, '0, '0, 112'h3C0D0C0B0A09080706050403023C);
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin @(negedge clk); cyc++; end
        chk("rd_latency", cyc, 5);
        drain();

        // Back-to-back write then read of the same row, no bubble
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 13'd20;
        cmd_byte_en = 14'h3FFF; cmd_wdata = {MW{8'h99}};
        #1; chk("b2b_ready_w", {127'b0, cmd_ready}, 128'd1);
        @(negedge clk);
        cmd_write = 1'b0;
        #1;
        chk("b2b_ready_r", {127'b0, cmd_ready}, 128'd1);
        chk("b2b_w_en", {127'b0, master_en}, 128'd1);
        chk("b2b_w_wen", master_write_en, 14'h3FFF);
        @(posedge clk);
        expq.push_back({MW{8'h99}});
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("b2b_r_en", {127'b0, master_en}, 128'd1);
        chk("b2b_r_wen", master_write_en, 128'd0);
        chk("b2b_r_addr", master_addr, 13'd20);
        @(negedge clk); #1;
        chk("b2b_idle", {127'b0, master_en}, 128'd0);
        drain();

        // buf_enable low for three cycles after a read issue
        do_cmd(1'b0, 13'd7, '0, '0, 112'hAA);
        cyc = 1;
        @(negedge clk); cyc++;
        buf_enable = 1'b0;
        #1; chk("stall_ready", {127'b0, cmd_ready}, 128'd0);
        repeat (3) begin @(negedge clk); cyc++; end
        chk("stall_no_push", {127'b0, rsp_valid}, 128'd0);
        buf_enable = 1'b1;
        while (!rsp_valid && cyc < 30) begin @(negedge clk); cyc++; end
        chk("stall_latency", cyc, 8);
        drain();

        // Credit: four reads fill the FIFO, the fifth waits for the first pop
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'(i);
            #1; chk("credit_ready", {127'b0, cmd_ready}, 128'd1);
            @(posedge clk);
            expq.push_back({MW{8'(8'hC0 + i)}});
            @(negedge clk);
        end
        cmd_addr = 13'd4;
        #1; chk("credit_block", {127'b0, cmd_ready}, 128'd0);
        repeat (8) @(negedge clk);
        #1;
        chk("credit_block_held", {127'b0, cmd_ready}, 128'd0);
        chk("credit_full_valid", {127'b0, rsp_valid}, 128'd1);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("credit_after_pop", {127'b0, cmd_ready}, 128'd1);
        @(posedge clk);
        expq.push_back({MW{8'hC4}});
        @(negedge clk);
        cmd_valid = 1'b0;
        drain();

`ifdef UB_BRIDGE_ADDR_CHK_EN
        // Out-of-range read: not issued, zero row in order, sticky error
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'd4096;
        #1; chk("bad_ready", {127'b0, cmd_ready}, 128'd1);
        @(posedge clk);
        expq.push_back('0);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("bad_no_issue", {127'b0, master_en}, 128'd0);
        do_cmd(1'b0, 13'd2, '0, '0, {MW{8'hC2}});
        chk("bad_err", {127'b0, cmd_err}, 128'd1);
        drain();
        chk("bad_err_sticky", {127'b0, cmd_err}, 128'd1);
`endif

        // Reset with two reads in flight
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'd0;
        @(posedge clk);
        @(negedge clk);
        cmd_addr = 13'd1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        expq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expq.delete();
        @(negedge clk); #1;
        chk("post_rst_ready", {127'b0, cmd_ready}, 128'd1);
        chk("post_rst_err", {127'b0, cmd_err}, 128'd0);
        cyc = 0;
        repeat (10) begin
            @(negedge clk); #1;
            if (rsp_valid) cyc++;
        end
        chk("post_rst_no_rsp", cyc, 0);
        chk("post_rst_empty", {127'b0, rsp_valid}, 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
